// File: rtl/grid_move_ctrl.sv
// Move sequencer for a token on a 16x16 grid: IDLE -> CALC -> COMMIT, one 4-bit add/sub per move.
// Optional macro WRAP_EN: out-of-range moves wrap (torus) instead of being blocked.
module grid_move_ctrl #(
  parameter logic [3:0] INIT_X = 4'd0,
  parameter logic [3:0] INIT_Y = 4'd0,
  parameter int         CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             home,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_dir,
  input  logic [1:0]       req_step,
  output logic [3:0]       pos_x,
  output logic [3:0]       pos_y,
  output logic             done,
  output logic             blocked,
  output logic [CNT_W-1:0] move_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       op_q, axis_q, cout_q, commit_ok;
  logic [1:0] step_q;
  logic [3:0] sum_q, operand, addend;
  logic [4:0] add_res;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = CALC;
      end
      CALC:    state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (home) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign accept = req_valid & req_ready & ~home;

  // Subtraction is two's complement: invert the zero-extended step and inject op as carry-in.
  assign operand = axis_q ? pos_y : pos_x;
  assign addend  = op_q ? ~{2'b00, step_q} : {2'b00, step_q};
  assign add_res = {1'b0, operand} + {1'b0, addend} + {4'b0000, op_q};

`ifdef WRAP_EN
  assign commit_ok = 1'b1;
`else
  // Add overflows when cout=1; subtract underflows when cout=0.
  assign commit_ok = ~(cout_q ^ op_q);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x    <= INIT_X;
      pos_y    <= INIT_Y;
      move_cnt <= '0;
      done     <= 1'b0;
      blocked  <= 1'b0;
      op_q     <= 1'b0;
      axis_q   <= 1'b0;
      step_q   <= 2'b00;
      sum_q    <= 4'h0;
      cout_q   <= 1'b0;
    end else if (home) begin
      pos_x   <= INIT_X;
      pos_y   <= INIT_Y;
      done    <= 1'b0;
      blocked <= 1'b0;
    end else begin
      done    <= 1'b0;
      blocked <= 1'b0;
      if (accept) begin
        op_q   <= req_dir[0];
        axis_q <= req_dir[1];
        step_q <= req_step;
      end
      if (state == CALC) begin
        sum_q  <= add_res[3:0];
        cout_q <= add_res[4];
      end
      if (state == COMMIT) begin
        done <= 1'b1;
        if (commit_ok) begin
          if (axis_q) pos_y <= sum_q;
          else        pos_x <= sum_q;
          move_cnt <= move_cnt + CNT_W'(1);
        end else begin
          blocked <= 1'b1;
        end
      end
    end
  end

endmodule
